// File: rtl/johnson_sequence_decoder.sv
// johnson_sequence_decoder
//   Receive-side monitor for a WIDTH-stage Johnson counter bus. It samples
//   code_in on code_valid, decodes it to a binary index and classifies each
//   step against the previous index. It acquires and tracks a count direction,
//   flags illegal codes and broken sequences, and counts steps while locked.
//
//   State table:
//     state     | meaning
//     UNLOCKED  | no trusted previous index; the next legal sample seeds it
//     ACQUIRE   | counting consecutive same-direction steps toward lock
//     LOCKED    | direction established; steps in dir are counted
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active-high
//   code_in      in   WIDTH  Johnson code under observation
//   code_valid   in   1      sample strobe
//   index        out  IDX_W  decoded index of last legal sample
//   index_valid  out  1      index holds a legal decoded value
//   dir          out  1      locked direction (1 = down, 0 = up)
//   locked       out  1      FSM in LOCKED
//   illegal      out  1      pulse: sampled code is not a Johnson code
//   seq_err      out  1      pulse: legal code that is not hold/+1/-1
//   step_count   out  CNT_W  steps accepted while LOCKED, wraps
module johnson_sequence_decoder #(
  parameter int WIDTH      = 4,
  parameter int LOCK_STEPS = 2,
  parameter int CNT_W      = 8,
  localparam int IDX_W     = $clog2(2*WIDTH),
  localparam int ACQ_W     = $clog2(LOCK_STEPS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_valid,
  output logic [IDX_W-1:0] index,
  output logic             index_valid,
  output logic             dir,
  output logic             locked,
  output logic             illegal,
  output logic             seq_err,
  output logic [CNT_W-1:0] step_count
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(2*WIDTH-1);
  localparam logic [ACQ_W-1:0] LOCK_CNT = ACQ_W'(LOCK_STEPS);

  state_t           state, state_nxt;
  logic [ACQ_W-1:0] acq_cnt, acq_cnt_nxt;
  logic             acq_dir, acq_dir_nxt;
  logic [IDX_W-1:0] index_nxt;
  logic             index_valid_nxt, dir_nxt, illegal_nxt, seq_err_nxt;
  logic [CNT_W-1:0] step_count_nxt;

  logic [WIDTH-1:0] inv_code;
  logic             code_legal;
  logic [IDX_W-1:0] ones, code_idx, idx_plus, idx_minus;
  logic             is_hold, is_up, is_down, step_dir;
  logic [ACQ_W-1:0] acq_cnt_step;

  // A legal Johnson code is a run of low ones, or (when the MSB is set) its
  // complement is. x & (x+1) == 0 tests for a run of low ones.
  always_comb begin
    inv_code   = ~code_in;
    code_legal = code_in[WIDTH-1] ? ((inv_code & (inv_code + 1'b1)) == '0)
                                  : ((code_in & (code_in + 1'b1)) == '0);
    ones = '0;
    for (int i = 0; i < WIDTH; i++) ones = ones + IDX_W'(code_in[i]);
    code_idx = code_in[WIDTH-1] ? IDX_W'(2*WIDTH) - ones : ones;
  end

  // Neighbours of the previous index, with explicit wrap since 2*WIDTH need
  // not be a power of two.
  always_comb begin
    idx_plus  = (index == MAX_IDX) ? '0 : index + 1'b1;
    idx_minus = (index == '0) ? MAX_IDX : index - 1'b1;
    is_hold   = (code_idx == index);
    is_up     = (code_idx == idx_plus);
    is_down   = (code_idx == idx_minus);
    step_dir  = is_down;
    // acq_cnt == 0 means no direction recorded yet, so any step starts at 1.
    acq_cnt_step = ((acq_cnt != '0) && (step_dir == acq_dir)) ? acq_cnt + 1'b1
                                                                : ACQ_W'(1);
  end

  always_comb begin
    state_nxt       = state;
    acq_cnt_nxt     = acq_cnt;
    acq_dir_nxt     = acq_dir;
    index_nxt       = index;
    index_valid_nxt = index_valid;
    dir_nxt         = dir;
    step_count_nxt  = step_count;
    illegal_nxt     = 1'b0;
    seq_err_nxt     = 1'b0;

    if (code_valid) begin
      if (!code_legal) begin
        illegal_nxt     = 1'b1;
        index_valid_nxt = 1'b0;
        state_nxt       = UNLOCKED;
      end else begin
        index_nxt       = code_idx;
        index_valid_nxt = 1'b1;
        case (state)
          UNLOCKED: begin
            state_nxt   = ACQUIRE;
            acq_cnt_nxt = '0;
          end
          ACQUIRE: begin
            if (is_up || is_down) begin
              acq_dir_nxt = step_dir;
              acq_cnt_nxt = acq_cnt_step;
              if (acq_cnt_step == LOCK_CNT) begin
                state_nxt = LOCKED;
                dir_nxt   = step_dir;
              end
            end else if (!is_hold) begin
              seq_err_nxt = 1'b1;
              acq_cnt_nxt = '0;
            end
          end
          LOCKED: begin
            if (is_up || is_down) begin
              if (step_dir == dir) begin
                step_count_nxt = step_count + 1'b1;
              end else begin
                seq_err_nxt = 1'b1;
                state_nxt   = ACQUIRE;
                acq_cnt_nxt = ACQ_W'(1);
                acq_dir_nxt = step_dir;
              end
            end else if (!is_hold) begin
              seq_err_nxt = 1'b1;
              state_nxt   = ACQUIRE;
              acq_cnt_nxt = '0;
            end
          end
          default: state_nxt = UNLOCKED;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= UNLOCKED;
      acq_cnt     <= '0;
      acq_dir     <= 1'b0;
      index       <= '0;
      index_valid <= 1'b0;
      dir         <= 1'b0;
      illegal     <= 1'b0;
      seq_err     <= 1'b0;
      step_count  <= '0;
    end else begin
      state       <= state_nxt;
      acq_cnt     <= acq_cnt_nxt;
      acq_dir     <= acq_dir_nxt;
      index       <= index_nxt;
      index_valid <= index_valid_nxt;
      dir         <= dir_nxt;
      illegal     <= illegal_nxt;
      seq_err     <= seq_err_nxt;
      step_count  <= step_count_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_johnson_sequence_decoder.sv
// Directed bench for johnson_sequence_decoder (WIDTH=4, LOCK_STEPS=2).
module tb_johnson_sequence_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] code_in = '0;
  logic       code_valid = 1'b0;
  logic [2:0] index;
  logic       index_valid, dir, locked, illegal, seq_err;
  logic [7:0] step_count;

  int checks = 0;
  int failures = 0;

  johnson_sequence_decoder #(.WIDTH(4), .LOCK_STEPS(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .index(index), .index_valid(index_valid), .dir(dir), .locked(locked),
    .illegal(illegal), .seq_err(seq_err), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic drive(input logic r, input logic v, input logic [3:0] c);
    rst = r;
    code_valid = v;
    code_in = c;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int idx, input int iv,
                            input int d, input int lk, input int ill,
                            input int se, input int sc);
    chk({tag, ".index"}, int'(index), idx);
    chk({tag, ".index_valid"}, int'(index_valid), iv);
    chk({tag, ".dir"}, int'(dir), d);
    chk({tag, ".locked"}, int'(locked), lk);
    chk({tag, ".illegal"}, int'(illegal), ill);
    chk({tag, ".seq_err"}, int'(seq_err), se);
    chk({tag, ".step_count"}, int'(step_count), sc);
  endtask

  initial begin
    drive(1, 0, 4'b0000);
    drive(1, 0, 4'b0000);
    expect_out("reset", 0, 0, 0, 0, 0, 0, 0);

    // 1: acquire and lock counting down
    drive(0, 1, 4'b0000); expect_out("t1.s1", 0, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b1000); expect_out("t1.s2", 7, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b1100); expect_out("t1.s3", 6, 1, 1, 1, 0, 0, 0);
    drive(0, 1, 4'b1110); expect_out("t1.s4", 5, 1, 1, 1, 0, 0, 1);
    drive(0, 1, 4'b1111); expect_out("t1.s5", 4, 1, 1, 1, 0, 0, 2);

    // 2: continue down through 1 -> 0 -> 7 wrap
    drive(0, 1, 4'b0111); expect_out("t2.s3", 3, 1, 1, 1, 0, 0, 3);
    drive(0, 1, 4'b0011); expect_out("t2.s2", 2, 1, 1, 1, 0, 0, 4);
    drive(0, 1, 4'b0001); expect_out("t2.s1", 1, 1, 1, 1, 0, 0, 5);
    drive(0, 1, 4'b0000); expect_out("t2.s0", 0, 1, 1, 1, 0, 0, 6);
    drive(0, 1, 4'b1000); expect_out("t2.wrap", 7, 1, 1, 1, 0, 0, 7);

    // 3: illegal code while locked
    drive(0, 1, 4'b0101); expect_out("t3.ill", 7, 0, 1, 0, 1, 0, 7);
    drive(0, 0, 4'b0101); expect_out("t3.after", 7, 0, 1, 0, 0, 0, 7);

    // 4: relock at 6, then jump 6 -> 3 and relock
    drive(0, 1, 4'b0000); expect_out("t4.a0", 0, 1, 1, 0, 0, 0, 7);
    drive(0, 1, 4'b1000); expect_out("t4.a1", 7, 1, 1, 0, 0, 0, 7);
    drive(0, 1, 4'b1100); expect_out("t4.a2", 6, 1, 1, 1, 0, 0, 7);
    drive(0, 1, 4'b0111); expect_out("t4.jump", 3, 1, 1, 0, 0, 1, 7);
    drive(0, 1, 4'b0011); expect_out("t4.r1", 2, 1, 1, 0, 0, 0, 7);
    drive(0, 1, 4'b0001); expect_out("t4.r2", 1, 1, 1, 1, 0, 0, 7);

    // 5: walk to 5, hold 1110, then idle with code_valid low
    drive(0, 1, 4'b0000); expect_out("t5.w0", 0, 1, 1, 1, 0, 0, 8);
    drive(0, 1, 4'b1000); expect_out("t5.w7", 7, 1, 1, 1, 0, 0, 9);
    drive(0, 1, 4'b1100); expect_out("t5.w6", 6, 1, 1, 1, 0, 0, 10);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 4'b1110); expect_out("t5.hold", 5, 1, 1, 1, 0, 0, 11);
    end
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 4'b0101); expect_out("t5.idle", 5, 1, 1, 1, 0, 0, 11);
    end

    // step against locked direction, relock counting up, up wrap 7 -> 0
    drive(0, 1, 4'b1100); expect_out("rev.against", 6, 1, 1, 0, 0, 1, 11);
    drive(0, 1, 4'b1000); expect_out("rev.lock_up", 7, 1, 0, 1, 0, 0, 11);
    drive(0, 1, 4'b0000); expect_out("rev.wrap_up", 0, 1, 0, 1, 0, 0, 12);

    // 6: reset wins over code_valid while locked
    drive(1, 1, 4'b0001); expect_out("t6.rst", 0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0011); expect_out("t6.s2", 2, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b0111); expect_out("t6.s3", 3, 1, 0, 0, 0, 0, 0);
    drive(0, 1, 4'b1111); expect_out("t6.s4", 4, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 4'b1110); expect_out("t6.s5", 5, 1, 0, 1, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
